regfile_param: RTL

Parametrised successor to the lab-1 register file for the pipelined ARM core. Holds DEPTH = 2**ADDR_W registers of WIDTH bits and serves NREAD independent combinational read ports plus one synchronous write port. Adds optional write-to-read bypass, a hardwired zero register, and a pending-write scoreboard that lets decode detect load-use hazards. Sits between decode (reads, issue) and writeback (write).

---
 rtl/regfile_pkg.sv | 15 +
 rtl/decoder5_32.sv | 15 +
 rtl/regfile_read_port.sv | 40 ++++
 rtl/regfile_param.sv | 103 ++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, zero-register index helper and read-address array type
// for the parametrised register file.
package regfile_pkg;

  localparam int unsigned WIDTH_DEF  = 64;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NREAD_DEF  = 2;

  function automatic int unsigned xzr_idx(input int unsigned addr_w);
    return (32'd1 << addr_w) - 32'd1;
  endfunction

  typedef logic [NREAD_DEF-1:0][ADDR_W_DEF-1:0] rd_addr_arr_t;

endpackage

// File: rtl/decoder5_32.sv
// Legacy 5-to-32 one-hot decoder with enable, reused for write select.
module decoder5_32 (
  input  logic [4:0]  sel_i,
  input  logic        en_i,
  output logic [31:0] dec_o
);

  always_comb begin
    dec_o = '0;
    if (en_i) begin
      dec_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_read_port.sv
// One combinational read port: zero register first, then same-cycle
// write forwarding, then the stored value; busy flag masked to match.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic [ADDR_W-1:0]                     raddr_i,
  input  logic [(2**ADDR_W)-1:0][WIDTH-1:0]     regs_i,
  input  logic [(2**ADDR_W)-1:0]                busy_i,
  input  logic                                  we_i,
  input  logic [ADDR_W-1:0]                     waddr_i,
  input  logic [WIDTH-1:0]                      wdata_i,
  output logic [WIDTH-1:0]                      rdata_o,
  output logic                                  rbusy_o
);

  localparam int unsigned XZR = xzr_idx(ADDR_W);

  logic is_zero;
  logic fwd;

  always_comb begin
    is_zero = ZERO_REG && (raddr_i == ADDR_W'(XZR));
    fwd     = BYPASS && we_i && (waddr_i == raddr_i);
    rdata_o = regs_i[raddr_i];
    rbusy_o = busy_i[raddr_i];
    if (is_zero) begin
      rdata_o = '0;
      rbusy_o = 1'b0;
    end else if (fwd) begin
      rdata_o = wdata_i;
      rbusy_o = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: NREAD combinational read ports, one write
// port, optional bypass, optional zero register, pending-write scoreboard.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NREAD    = NREAD_DEF,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      RegWrite,
  input  logic [ADDR_W-1:0]         WriteRegister,
  input  logic [WIDTH-1:0]          WriteData,
  input  logic [NREAD*ADDR_W-1:0]   ReadRegister,
  output logic [NREAD*WIDTH-1:0]    ReadData,
  input  logic                      IssueValid,
  input  logic [ADDR_W-1:0]         IssueRegister,
  output logic [NREAD-1:0]          ReadBusy
);

  localparam int unsigned         DEPTH = 2**ADDR_W;
  localparam int unsigned         XZR   = xzr_idx(ADDR_W);
  localparam logic [DEPTH-1:0]    ZMASK = ZERO_REG ? (DEPTH'(1'b1) << XZR) : '0;

  logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]            busy_q, busy_d;
  logic [DEPTH-1:0]            wr_dec;
  logic [DEPTH-1:0]            wr_mask;
  logic [DEPTH-1:0]            iss_dec;
  logic                        wr_en;

  // Gating with reset keeps the bypass path from leaking WriteData while
  // the file is held in reset; the storage itself is already frozen there.
  assign wr_en = RegWrite & reset;

  if (ADDR_W == 5) begin : g_dec5
    decoder5_32 u_wdec (
      .sel_i (WriteRegister),
      .en_i  (wr_en),
      .dec_o (wr_dec)
    );
  end else begin : g_decn
    always_comb begin
      wr_dec = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        wr_dec[i] = wr_en && (WriteRegister == ADDR_W'(i));
      end
    end
  end

  assign wr_mask = wr_dec & ~ZMASK;

  always_comb begin
    iss_dec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      iss_dec[i] = IssueValid && (IssueRegister == ADDR_W'(i));
    end
  end

  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_mask[i]) begin
        regs_d[i] = WriteData;
      end
    end
  end

  // Issue is younger than writeback, so its set overrides the clear.
  assign busy_d = ((busy_q & ~wr_dec) | iss_dec) & ~ZMASK;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    regfile_read_port #(
      .WIDTH    (WIDTH),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rp (
      .raddr_i (ReadRegister[p*ADDR_W +: ADDR_W]),
      .regs_i  (regs_q),
      .busy_i  (busy_q),
      .we_i    (wr_en),
      .waddr_i (WriteRegister),
      .wdata_i (WriteData),
      .rdata_o (ReadData[p*WIDTH +: WIDTH]),
      .rbusy_o (ReadBusy[p])
    );
  end

endmodule
